exc_ctrl: RTL and testbench

Exception and return sequencer between the writeback stage and the CSR unit. Each cycle it takes the retiring instruction's exception flags, the pending-interrupt indication and `ertn`. It picks one event by fixed priority and drives the CSR unit's commit inputs (`wb_ex`, code, bad address, `ertn_flush`). It also runs a flush/redirect handshake with fetch, so that exactly one redirect to `ex_entry` or `ex_exit` is delivered per event.

---
 rtl/exc_pkg.sv | 33 +++
 rtl/exc_ctrl_if.sv | 12 +
 rtl/exc_prio_enc.sv | 46 ++++
 rtl/exc_ctrl.sv | 122 ++++++++++++
 tb/tb_exc_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared constants and types for the exception/return sequencer.
//   - ECODE_* / ESUB_* : exception codes and subcode committed to the CSR unit
//   - EXC_*            : bit positions inside ws_exc {ALE, SYS, BRK, INE, ADEF, rsvd}
//   - ST_*             : sequencer state encoding
//   - exc_sel_t        : result of the priority encoder
package exc_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [8:0] ESUB_NONE  = 9'h000;

  localparam int unsigned EXC_RSVD = 0;
  localparam int unsigned EXC_ADEF = 1;
  localparam int unsigned EXC_INE  = 2;
  localparam int unsigned EXC_BRK  = 3;
  localparam int unsigned EXC_SYS  = 4;
  localparam int unsigned EXC_ALE  = 5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  typedef struct packed {
    logic        take;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr;
  } exc_sel_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_redir_if: flush/redirect handshake between the exception sequencer and fetch.
//   redirect_valid : sequencer -> fetch, a redirect is pending
//   redirect_pc    : sequencer -> fetch, target PC (stable while valid)
//   redirect_ready : fetch -> sequencer, redirect accepted this cycle
interface exc_redir_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: purely combinational fixed-priority event selector.
//   Inputs : csr_has_int, ws_exc, ws_pc, ws_vaddr
//   Output : sel (take flag, ecode, esubcode, badvaddr)
//   Priority: INT > ADEF > INE > BRK > SYS > ALE. Only ADEF and ALE carry an address.
import exc_pkg::*;

module exc_prio_enc (
  input  logic        csr_has_int,
  input  logic [5:0]  ws_exc,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_vaddr,
  output exc_sel_t    sel
);

  // Pick the single highest-priority event; codes stay zero when nothing is pending.
  always_comb begin
    sel.take     = 1'b0;
    sel.ecode    = 6'h00;
    sel.esubcode = ESUB_NONE;
    sel.badvaddr = 32'h0000_0000;
    if (csr_has_int) begin
      sel.take  = 1'b1;
      sel.ecode = ECODE_INT;
    end else if (ws_exc[EXC_ADEF]) begin
      sel.take     = 1'b1;
      sel.ecode    = ECODE_ADEF;
      sel.badvaddr = ws_pc;
    end else if (ws_exc[EXC_INE]) begin
      sel.take  = 1'b1;
      sel.ecode = ECODE_INE;
    end else if (ws_exc[EXC_BRK]) begin
      sel.take  = 1'b1;
      sel.ecode = ECODE_BRK;
    end else if (ws_exc[EXC_SYS]) begin
      sel.take  = 1'b1;
      sel.ecode = ECODE_SYS;
    end else if (ws_exc[EXC_ALE]) begin
      sel.take     = 1'b1;
      sel.ecode    = ECODE_ALE;
      sel.badvaddr = ws_vaddr;
    end else begin
      sel.take = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception / ertn sequencer between writeback and the CSR unit.
//   clk, resetn (sync, active-low)
//   ws_*        : retiring instruction (valid, pc, exc flags, vaddr, ertn, csr_we)
//   csr_has_int : pending enabled interrupt from the CSR unit
//   ex_entry / ex_exit : handler entry / return address from the CSR unit
//   wb_ex, wb_ecode, wb_esubcode, wb_badvaddr, ertn_flush, csr_we_out : CSR commit
//     inputs, combinational in the retire cycle
//   flush : kill all stages, from the retire cycle through the redirect handshake
//   redir : redirect handshake to fetch (master side)
import exc_pkg::*;

module exc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ws_valid,
  input  logic [31:0]   ws_pc,
  input  logic [5:0]    ws_exc,
  input  logic [31:0]   ws_vaddr,
  input  logic          ws_ertn,
  input  logic          ws_csr_we,
  input  logic          csr_has_int,
  input  logic [31:0]   ex_entry,
  input  logic [31:0]   ex_exit,
  output logic          wb_ex,
  output logic [5:0]    wb_ecode,
  output logic [8:0]    wb_esubcode,
  output logic [31:0]   wb_badvaddr,
  output logic          ertn_flush,
  output logic          csr_we_out,
  output logic          flush,
  exc_redir_if.master   redir
);

  logic [0:0]  state_r;
  logic [31:0] redirect_pc_r;
  exc_sel_t    sel_s;
  logic        fire_s;
  logic        exc_take_s;
  logic        ertn_take_s;
  logic        in_redir_s;
  logic        handshake_s;

  exc_prio_enc u_prio (
    .csr_has_int (csr_has_int),
    .ws_exc      (ws_exc),
    .ws_pc       (ws_pc),
    .ws_vaddr    (ws_vaddr),
    .sel         (sel_s)
  );

  // Retirement is only accepted in IDLE and never while reset is asserted,
  // so nothing commits to the CSR unit during a reset cycle.
  always_comb begin
    in_redir_s  = (state_r == ST_REDIR);
    fire_s      = (state_r == ST_IDLE) & ws_valid & resetn;
    exc_take_s  = fire_s & sel_s.take;
    ertn_take_s = fire_s & ws_ertn & ~exc_take_s;
    handshake_s = in_redir_s & redir.redirect_ready;
  end

  // CSR commit outputs and pipeline flush; codes are forced to zero without an exception.
  always_comb begin
    wb_ex       = exc_take_s;
    ertn_flush  = ertn_take_s;
    csr_we_out  = fire_s & ws_csr_we & ~exc_take_s;
    flush       = exc_take_s | ertn_take_s | (in_redir_s & resetn);
    if (exc_take_s) begin
      wb_ecode    = sel_s.ecode;
      wb_esubcode = sel_s.esubcode;
      wb_badvaddr = sel_s.badvaddr;
    end else begin
      wb_ecode    = 6'h00;
      wb_esubcode = 9'h000;
      wb_badvaddr = 32'h0000_0000;
    end
  end

  assign redir.redirect_valid = in_redir_s;
  assign redir.redirect_pc    = redirect_pc_r;

  // Sequencer state: one redirect per event, held until fetch accepts it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (exc_take_s | ertn_take_s) begin
            state_r <= ST_REDIR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REDIR: begin
          if (handshake_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_REDIR;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Redirect target: ex_entry/ex_exit are sampled in the retire cycle, before
  // the CSR unit updates them, and held stable until the handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      redirect_pc_r <= RESET_PC;
    end else if (exc_take_s) begin
      redirect_pc_r <= ex_entry;
    end else if (ertn_take_s) begin
      redirect_pc_r <= ex_exit;
    end else begin
      redirect_pc_r <= redirect_pc_r;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked at the falling edge
// (combinational results for the current cycle) or just after the next rising edge.
module tb_exc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk;
  logic        resetn;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [5:0]  ws_exc;
  logic [31:0] ws_vaddr;
  logic        ws_ertn;
  logic        ws_csr_we;
  logic        csr_has_int;
  logic [31:0] ex_entry;
  logic [31:0] ex_exit;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_badvaddr;
  logic        ertn_flush;
  logic        csr_we_out;
  logic        flush;

  int n_checks;
  int n_fails;

  exc_redir_if redir_if ();

  exc_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ws_valid    (ws_valid),
    .ws_pc       (ws_pc),
    .ws_exc      (ws_exc),
    .ws_vaddr    (ws_vaddr),
    .ws_ertn     (ws_ertn),
    .ws_csr_we   (ws_csr_we),
    .csr_has_int (csr_has_int),
    .ex_entry    (ex_entry),
    .ex_exit     (ex_exit),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_badvaddr (wb_badvaddr),
    .ertn_flush  (ertn_flush),
    .csr_we_out  (csr_we_out),
    .flush       (flush),
    .redir       (redir_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ws_valid    = 1'b0;
    ws_pc       = 32'h0000_0000;
    ws_exc      = 6'b000000;
    ws_vaddr    = 32'h0000_0000;
    ws_ertn     = 1'b0;
    ws_csr_we   = 1'b0;
    csr_has_int = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [5:0] exc,
                        input logic [31:0] va, input logic ertn, input logic cwe);
    ws_valid  = 1'b1;
    ws_pc     = pc;
    ws_exc    = exc;
    ws_vaddr  = va;
    ws_ertn   = ertn;
    ws_csr_we = cwe;
  endtask

  // From the retire cycle T: advance to T+1 with inputs idle, accept, reach IDLE at T+2.
  task automatic accept(input string tag, input logic [31:0] exp_pc);
    tick();
    idle_inputs();
    redir_if.redirect_ready = 1'b1;
    mid();
    chk({tag, "_valid"}, {31'd0, redir_if.redirect_valid}, 32'd1);
    chk({tag, "_pc"}, redir_if.redirect_pc, exp_pc);
    chk({tag, "_flush_hs"}, {31'd0, flush}, 32'd1);
    tick();
    redir_if.redirect_ready = 1'b0;
    mid();
    chk({tag, "_idle"}, {31'd0, redir_if.redirect_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    resetn   = 1'b0;
    ex_entry = 32'h1c00_8000;
    ex_exit  = 32'h1c00_0040;
    redir_if.redirect_ready = 1'b0;
    tick();
    tick();
    mid();
    chk("rst_valid", {31'd0, redir_if.redirect_valid}, 32'd0);
    chk("rst_pc", redir_if.redirect_pc, RESET_PC);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_wb_ex", {31'd0, wb_ex}, 32'd0);
    tick();
    resetn = 1'b1;

    // SYS with fetch stalling three cycles
    retire(32'h1c00_0010, 6'b010000, 32'h0000_0000, 1'b0, 1'b0);
    mid();
    chk("sys_wb_ex", {31'd0, wb_ex}, 32'd1);
    chk("sys_ecode", {26'd0, wb_ecode}, 32'h0B);
    chk("sys_esub", {23'd0, wb_esubcode}, 32'd0);
    chk("sys_badv", wb_badvaddr, 32'd0);
    chk("sys_flush_T", {31'd0, flush}, 32'd1);
    chk("sys_valid_T", {31'd0, redir_if.redirect_valid}, 32'd0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("stall_valid", {31'd0, redir_if.redirect_valid}, 32'd1);
      chk("stall_flush", {31'd0, flush}, 32'd1);
      chk("stall_pc", redir_if.redirect_pc, 32'h1c00_8000);
      chk("stall_wb_ex", {31'd0, wb_ex}, 32'd0);
      tick();
    end
    redir_if.redirect_ready = 1'b1;
    mid();
    chk("hs_flush", {31'd0, flush}, 32'd1);
    tick();
    redir_if.redirect_ready = 1'b0;
    mid();
    chk("post_hs_valid", {31'd0, redir_if.redirect_valid}, 32'd0);
    chk("post_hs_flush", {31'd0, flush}, 32'd0);

    // ADEF beats ALE; badv is the PC
    tick();
    ex_entry = 32'h1c00_9000;
    retire(32'h1c00_0103, 6'b100010, 32'h1234_5678, 1'b0, 1'b0);
    mid();
    chk("adef_ecode", {26'd0, wb_ecode}, 32'h08);
    chk("adef_badv", wb_badvaddr, 32'h1c00_0103);
    accept("adef", 32'h1c00_9000);

    // interrupt beats INE
    tick();
    csr_has_int = 1'b1;
    retire(32'h1c00_0200, 6'b000100, 32'h0000_0000, 1'b0, 1'b0);
    mid();
    chk("int_wb_ex", {31'd0, wb_ex}, 32'd1);
    chk("int_ecode", {26'd0, wb_ecode}, 32'h00);
    chk("int_badv", wb_badvaddr, 32'd0);
    accept("int", 32'h1c00_9000);

    // ALE alone
    tick();
    retire(32'h1c00_0300, 6'b100000, 32'h8000_0002, 1'b0, 1'b0);
    mid();
    chk("ale_ecode", {26'd0, wb_ecode}, 32'h09);
    chk("ale_badv", wb_badvaddr, 32'h8000_0002);
    accept("ale", 32'h1c00_9000);

    // ertn with no exception
    tick();
    retire(32'h1c00_0400, 6'b000000, 32'h0000_0000, 1'b1, 1'b0);
    mid();
    chk("ertn_flush", {31'd0, ertn_flush}, 32'd1);
    chk("ertn_wb_ex", {31'd0, wb_ex}, 32'd0);
    chk("ertn_ecode", {26'd0, wb_ecode}, 32'h00);
    chk("ertn_flush_T", {31'd0, flush}, 32'd1);
    accept("ertn", 32'h1c00_0040);

    // ertn plus BRK: exception wins
    tick();
    retire(32'h1c00_0500, 6'b001000, 32'h0000_0000, 1'b1, 1'b0);
    mid();
    chk("brk_wb_ex", {31'd0, wb_ex}, 32'd1);
    chk("brk_ecode", {26'd0, wb_ecode}, 32'h0C);
    chk("brk_ertn", {31'd0, ertn_flush}, 32'd0);
    accept("brk", 32'h1c00_9000);

    // CSR write suppressed by SYS, allowed alone
    tick();
    retire(32'h1c00_0600, 6'b010000, 32'h0000_0000, 1'b0, 1'b1);
    mid();
    chk("cwe_sys", {31'd0, csr_we_out}, 32'd0);
    accept("cwe_sys", 32'h1c00_9000);
    tick();
    redir_if.redirect_ready = 1'b1;
    retire(32'h1c00_0700, 6'b000000, 32'h0000_0000, 1'b0, 1'b1);
    mid();
    chk("cwe_alone", {31'd0, csr_we_out}, 32'd1);
    chk("cwe_flush", {31'd0, flush}, 32'd0);
    chk("cwe_wb_ex", {31'd0, wb_ex}, 32'd0);
    tick();
    idle_inputs();
    redir_if.redirect_ready = 1'b0;
    mid();
    chk("cwe_no_redir", {31'd0, redir_if.redirect_valid}, 32'd0);

    // retirement ignored in REDIR, then reset discards the redirect
    tick();
    retire(32'h1c00_0800, 6'b010000, 32'h0000_0000, 1'b0, 1'b0);
    tick();
    ex_entry = 32'h1c00_a000;
    retire(32'h1c00_0804, 6'b010000, 32'h0000_0000, 1'b1, 1'b1);
    mid();
    chk("redir_wb_ex", {31'd0, wb_ex}, 32'd0);
    chk("redir_ertn", {31'd0, ertn_flush}, 32'd0);
    chk("redir_cwe", {31'd0, csr_we_out}, 32'd0);
    chk("redir_flush", {31'd0, flush}, 32'd1);
    tick();
    idle_inputs();
    chk("redir_pc_kept", redir_if.redirect_pc, 32'h1c00_9000);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    mid();
    chk("rst2_valid", {31'd0, redir_if.redirect_valid}, 32'd0);
    chk("rst2_pc", redir_if.redirect_pc, RESET_PC);
    chk("rst2_flush", {31'd0, flush}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
